tff_count_seq: RTL and testbench

- Sequencer for a bank of WIDTH T flip-flops used as a programmable up/down counter/divider.
- The controller owns the T bank. Each cycle it computes the per-bit toggle vector, which covers three cases:
  - loading a start value (toggle = q ^ init);
  - stepping up or down;
  - holding.
- Runs one count sequence per start request, with a busy/done handshake. Sits between a host FSM and the T-FF datapath.

---
 rtl/tff_count_pkg.sv | 14 +
 rtl/tff_bit.sv | 17 +
 rtl/tff_count_seq.sv | 97 +++++++++
 tb/tb_tff_count_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tff_count_pkg.sv
// Shared types for the T-FF counter sequencer: controller states and count directions.
package tff_count_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop with async active-low clear; toggles on each edge where t is high.
module tff_bit (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)   q <= 1'b0;
        else if (t) q <= ~q;
    end

    assign q_bar = ~q;

endmodule

// File: rtl/tff_count_seq.sv
// Sequencer driving a bank of T flip-flops as a loadable up/down counter with busy/done handshake.
// Optional: define TFF_COUNT_SEQ_AUTORELOAD_EN to restart from DONE into LOAD (free-running divider).
module tff_count_seq
    import tff_count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec
);

    state_t           state, nstate;
    logic             dir_r;
    logic [WIDTH-1:0] lim_r;
    logic [WIDTH-1:0] qb, up_t, dn_t, step_t, step_q, init_v, tgt_v;

    // Ripple toggle terms: a bit flips when every lower bit is 1 (up) or 0 (down).
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit u_bit (
            .clk   (clk),
            .rst   (rst),
            .t     (t_vec[i]),
            .q     (q[i]),
            .q_bar (qb[i])
        );
        if (i == 0) begin : g_lsb
            assign up_t[i] = 1'b1;
            assign dn_t[i] = 1'b1;
        end else begin : g_upper
            assign up_t[i] = &q[i-1:0];
            assign dn_t[i] = &qb[i-1:0];
        end
    end

    assign init_v = (dir_r == DIR_UP) ? '0 : lim_r;
    assign tgt_v  = (dir_r == DIR_UP) ? lim_r : '0;
    assign step_t = (dir_r == DIR_UP) ? up_t : dn_t;
    assign step_q = q ^ step_t;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            dir_r <= 1'b0;
            lim_r <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && start) begin
                dir_r <= dir;
                lim_r <= limit;
            end
        end
    end

    always_comb begin
        nstate = state;
        t_vec  = '0;
        case (state)
            IDLE: if (start) nstate = LOAD;
            LOAD: begin
                if (abort) nstate = IDLE;
                else begin
                    t_vec  = q ^ init_v;
                    nstate = (init_v == tgt_v) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort outranks both hold and reaching the target
                if (abort) nstate = IDLE;
                else if (!hold) begin
                    t_vec = step_t;
                    if (step_q == tgt_v) nstate = DONE;
                end
            end
            DONE: begin
`ifdef TFF_COUNT_SEQ_AUTORELOAD_EN
                nstate = LOAD;
`else
                nstate = IDLE;
`endif
            end
            default: nstate = IDLE;
        endcase
    end

    assign busy = (state == LOAD) || (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_tff_count_seq.sv
// Randomized and directed bench for tff_count_seq against an arithmetic reference model.
module tb_tff_count_seq;

    localparam int W = 8;

    logic         clk = 1'b0, rst = 1'b0;
    logic         start = 1'b0, dir = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [W-1:0] limit = '0;
    logic         busy, done;
    logic [W-1:0] q, t_vec;

    int n_chk = 0, n_pass = 0, edges = 0;

    // reference model: phase 0 idle, 1 load, 2 run, 3 done; value kept as plain integer arithmetic
    int           m_ph = 0;
    logic [W-1:0] m_q = '0, m_lim = '0;
    logic         m_up = 1'b0;

    always #5 clk = ~clk;

    tff_count_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .limit(limit),
        .hold(hold), .abort(abort), .busy(busy), .done(done), .q(q), .t_vec(t_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_tick();
        logic [W-1:0] nq;
        int           nph;
        if (!rst) begin
            m_ph = 0; m_q = '0; m_up = 1'b0; m_lim = '0;
            check("rst_q", q, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_t", t_vec, 0);
            return;
        end
        nq  = m_q;
        nph = m_ph;
        case (m_ph)
            0: if (start) begin m_up = dir; m_lim = limit; nph = 1; end
            1: if (abort) nph = 0;
               else begin
                   nq  = m_up ? '0 : m_lim;
                   nph = (m_lim == 0) ? 3 : 2;
               end
            2: if (abort) nph = 0;
               else if (!hold) begin
                   nq = m_up ? W'(int'(m_q) + 1) : W'(int'(m_q) - 1);
                   if (nq == (m_up ? m_lim : '0)) nph = 3;
               end
            default: begin
`ifdef TFF_COUNT_SEQ_AUTORELOAD_EN
                nph = 1;
`else
                nph = 0;
`endif
            end
        endcase
        check("q", q, m_q);
        check("busy", busy, (m_ph == 1 || m_ph == 2));
        check("done", done, (m_ph == 3));
        check("t_vec", t_vec, m_q ^ nq);
        m_q  = nq;
        m_ph = nph;
    endtask

    task automatic step();
        @(negedge clk);
        model_tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic start_seq(input logic d, input logic [W-1:0] lim);
        start = 1'b1; dir = d; limit = lim;
        step();
        start = 1'b0;
        // later changes must be ignored by the latched sequence
        dir = 1'($urandom); limit = W'($urandom);
    endtask

    task automatic wait_q(input logic [W-1:0] v);
        int k = 0;
        while (q !== v && k < 300) begin step(); k++; end
        check("wait_q", q, v);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 400) begin step(); k++; end
        check("wait_done", done, 1);
    endtask

    // leave DONE and make sure the block ends up in IDLE in either build
    task automatic finish_seq();
        step();
`ifdef TFF_COUNT_SEQ_AUTORELOAD_EN
        abort = 1'b1; step(); abort = 1'b0;
`endif
        check("idle_busy", busy, 0);
    endtask

    task automatic run_seq(input string tag, input logic d, input logic [W-1:0] lim,
                           input int exp_edges, input logic [W-1:0] exp_q);
        int s = edges;
        start_seq(d, lim);
        wait_done();
        check({tag, "_lat"}, edges - s, exp_edges);
        check({tag, "_q"}, q, exp_q);
        finish_seq();
    endtask

    initial begin
        int s;
        int last;
        repeat (3) step();
        rst = 1'b1;
        step();

        run_seq("up5", 1'b1, 8'd5, 7, 8'd5);
        run_seq("dn9", 1'b0, 8'd9, 11, 8'd0);
        run_seq("l0", 1'b1, 8'd0, 2, 8'd0);
        run_seq("up255", 1'b1, 8'd255, 257, 8'hFF);

        // hold for four cycles at q=3 delays done by four edges
        s = edges;
        start_seq(1'b1, 8'd10);
        wait_q(8'd3);
        hold = 1'b1; repeat (4) step(); hold = 1'b0;
        check("hold_q", q, 3);
        wait_done();
        check("hold_lat", edges - s, 16);
        finish_seq();

        // start during RUN ignored, then abort beats hold at q=6
        start_seq(1'b1, 8'd10);
        wait_q(8'd2);
        start = 1'b1; dir = 1'b0; limit = 8'd3; step(); start = 1'b0;
        wait_q(8'd6);
        hold = 1'b1; abort = 1'b1; step(); hold = 1'b0; abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_q", q, 6);
        step();
        check("abort_done", done, 0);

        // asynchronous reset mid-sequence acts without a clock edge
        start_seq(1'b1, 8'd10);
        wait_q(8'd4);
        #2 rst = 1'b0;
        #1;
        check("arst_q", q, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        m_ph = 0; m_q = '0; m_up = 1'b0; m_lim = '0;
        step(); step();
        rst = 1'b1;
        step();

`ifdef TFF_COUNT_SEQ_AUTORELOAD_EN
        start_seq(1'b1, 8'd3);
        last = -1;
        repeat (30) begin
            step();
            if (done) begin
                if (last >= 0) check("reload_period", edges - last, 5);
                last = edges;
            end
        end
        abort = 1'b1; step(); step(); abort = 1'b0;
        check("reload_abort_busy", busy, 0);
`endif

        repeat (600) begin
            start = ($urandom_range(0, 9) < 3);
            dir   = 1'($urandom);
            limit = W'($urandom_range(0, 12));
            hold  = ($urandom_range(0, 9) < 2);
            abort = ($urandom_range(0, 99) < 4);
            step();
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
